// File: rtl/alu_md.sv
// Integer ALU with single-cycle logic/arith/shift ops and iterative
// shift-add multiply / restoring divide on operand magnitudes.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       control,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] resultado,
  output logic             zero,
  output logic             busy,
  output logic             valid
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [SW-1:0]    cnt;
  logic [2:0]       op;
  logic             sx_q, sy_q, div0_q;
  logic [WIDTH-1:0] a_mag, b_mag, hi, lo, x_q;

  logic [WIDTH-1:0] sc_res, lui;
  logic [SW-1:0]    shamt;
  logic             is_iter;
  logic             sx_n, sy_n;
  logic [WIDTH-1:0] xm, ym;

  assign is_iter = control[4] & ~control[3];
  assign lui     = {y[WIDTH-1:12], 12'd0};
  assign shamt   = y[SW-1:0];

  always_comb begin
    sc_res = '0;
    case (control)
      5'b00000: sc_res = x + y;
      5'b00111: sc_res = x - y;
      5'b00100: sc_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      5'b01100: sc_res = {{(WIDTH-1){1'b0}}, (x < y)};
      5'b00010: sc_res = x & y;
      5'b00001: sc_res = x | y;
      5'b01001: sc_res = x ^ y;
      5'b00110: sc_res = lui;
      5'b00101: sc_res = lui + x;
      5'b00011: sc_res = x << shamt;
      5'b01101: sc_res = x >> shamt;
      5'b01110: sc_res = $unsigned($signed(x) >>> shamt);
      default:  sc_res = '0;
    endcase
  end

  // Which operands are treated as signed for the iterative ops.
  always_comb begin
    sx_n = 1'b0;
    sy_n = 1'b0;
    case (control[2:0])
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sx_n = x[WIDTH-1];
        sy_n = y[WIDTH-1];
      end
      3'b010:  sx_n = x[WIDTH-1];
      default: ;
    endcase
  end

  assign xm = sx_n ? -x : x;
  assign ym = sy_n ? -y : y;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic [WIDTH:0]     rem_sh, diff;

  assign add_sum  = {1'b0, hi} + {1'b0, a_mag};
  assign mul_hi_n = lo[0] ? add_sum[WIDTH:1] : {1'b0, hi[WIDTH-1:1]};
  assign mul_lo_n = {(lo[0] ? add_sum[0] : hi[0]), lo[WIDTH-1:1]};
  assign rem_sh   = {hi, lo[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, b_mag};

  logic [2*WIDTH-1:0] prod, prod_c;
  logic [WIDTH-1:0]   q_c, r_c, fin;

  assign prod   = {hi, lo};
  assign prod_c = (sx_q ^ sy_q) ? -prod : prod;
  assign q_c    = (sx_q ^ sy_q) ? -lo : lo;
  assign r_c    = sx_q ? -hi : hi;

  always_comb begin
    if (op[2]) begin
      if (div0_q) fin = op[1] ? x_q : '1;
      else        fin = op[1] ? r_c : q_c;
    end else begin
      fin = (op[1:0] == 2'b00) ? prod_c[WIDTH-1:0] : prod_c[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op        <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      div0_q    <= 1'b0;
      a_mag     <= '0;
      b_mag     <= '0;
      hi        <= '0;
      lo        <= '0;
      x_q       <= '0;
      resultado <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_iter) begin
              op     <= control[2:0];
              sx_q   <= sx_n;
              sy_q   <= sy_n;
              div0_q <= (y == '0);
              x_q    <= x;
              a_mag  <= xm;
              b_mag  <= ym;
              hi     <= '0;
              lo     <= control[2] ? xm : ym;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_ITER;
            end else begin
              resultado <= sc_res;
              valid     <= 1'b1;
            end
          end
        end
        S_ITER: begin
          if (op[2]) begin
            if (!diff[WIDTH]) begin
              hi <= diff[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= rem_sh[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= mul_hi_n;
            lo <= mul_lo_n;
          end
          cnt <= cnt + SW'(1);
          if (cnt == CNT_LAST) state <= S_DONE;
        end
        S_DONE: begin
          resultado <= fin;
          valid     <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign zero = (resultado == '0);

endmodule
